// File: rtl/fp32_pkg.sv
// Shared fp32 constants, field widths, accumulator-controller state encoding
// and a NaN classifier used by the controller and its bench.
package fp32_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_POS_INF  = 32'h7F80_0000;
  localparam logic [31:0] FP32_NEG_INF  = 32'hFF80_0000;

  localparam logic [1:0] ST_ACC_ENC = 2'd0;
  localparam logic [1:0] ST_ADD_ENC = 2'd1;
  localparam logic [1:0] ST_OUT_ENC = 2'd2;

  typedef enum logic [1:0] {
    S_ACC = ST_ACC_ENC,
    S_ADD = ST_ADD_ENC,
    S_OUT = ST_OUT_ENC
  } state_e;

  function automatic logic is_nan(input logic [31:0] v);
    return (v[MAN_W+EXP_W-1:MAN_W] == {EXP_W{1'b1}}) && (v[MAN_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/fp_accum_ctrl.sv
// Streaming accumulator controller: feeds an external combinational fp32
// add_sub one operand at a time and presents the packet total with sticky flags.
module fp_accum_ctrl
  import fp32_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic [31:0]      op_a,
  output logic [31:0]      op_b,
  output logic             op_sub,
  input  logic [31:0]      op_result,
  input  logic             op_overflow,
  input  logic             op_underflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic             out_overflow,
  output logic             out_underflow,
  output logic             out_nan,
  output logic [CNT_W-1:0] out_count
);

  state_e             state_q;
  logic [31:0]        acc_q;
  logic [31:0]        opb_q;
  logic               sub_q;
  logic               last_q;
  logic               ovf_q;
  logic               unf_q;
  logic               nan_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic               in_ready_q;
  logic               out_valid_q;

  // Element counter sticks at all-ones until the result is handed off.
  always_comb begin
    count_d = count_q;
    if (count_q != {CNT_W{1'b1}}) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ACC;
      acc_q       <= FP32_POS_ZERO;
      opb_q       <= '0;
      sub_q       <= 1'b0;
      last_q      <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      nan_q       <= 1'b0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_ACC: begin
          if (in_valid) begin
            opb_q      <= in_data;
            sub_q      <= in_sub;
            last_q     <= in_last;
            in_ready_q <= 1'b0;
            state_q    <= S_ADD;
          end
        end
        S_ADD: begin
          // The NaN flag tracks the value being written into the accumulator,
          // so it lines up with out_sum once S_OUT is reached.
          acc_q   <= op_result;
          ovf_q   <= ovf_q | op_overflow;
          unf_q   <= unf_q | op_underflow;
          nan_q   <= is_nan(op_result);
          count_q <= count_d;
          if (last_q) begin
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= S_ACC;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            acc_q       <= FP32_POS_ZERO;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            nan_q       <= 1'b0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_ACC;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_ACC;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign op_a          = acc_q;
  assign op_b          = opb_q;
  assign op_sub        = sub_q;
  assign out_valid     = out_valid_q;
  assign out_sum       = acc_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;
  assign out_nan       = nan_q;
  assign out_count     = count_q;

endmodule

// File: tb/tb_fp_accum_ctrl.sv
// Bench for fp_accum_ctrl: two instances (16-bit and 2-bit counters) driven in
// lockstep, each wired to a behavioural fp32 adder; results checked per packet.
module tb_fp_accum_ctrl;
  import fp32_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
  } addOut_t;

  logic clk = 1'b0;
  logic rst, inValid, inSub, inLast, outReady;
  logic [31:0] inData;

  logic inReadyA, opSubA, opOvfA, opUnfA, outValidA, outOvfA, outUnfA, outNanA;
  logic [31:0] opAA, opBA, opResA, outSumA;
  logic [15:0] outCountA;

  logic inReadyB, opSubB, opOvfB, opUnfB, outValidB, outOvfB, outUnfB, outNanB;
  logic [31:0] opAB, opBB, opResB, outSumB;
  logic [1:0] outCountB;

  int errorCount = 0;
  int checkCount = 0;

  logic [31:0] pktData[$];
  logic        pktSub[$];
  logic [31:0] gotSum;
  logic        gotOvf, gotUnf, gotNan;
  logic [15:0] gotCountA;
  logic [1:0]  gotCountB;

  always #5 clk = ~clk;

  fp_accum_ctrl #(.CNT_W(16)) dutA (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReadyA), .in_data(inData),
    .in_sub(inSub), .in_last(inLast), .op_a(opAA), .op_b(opBA), .op_sub(opSubA),
    .op_result(opResA), .op_overflow(opOvfA), .op_underflow(opUnfA),
    .out_valid(outValidA), .out_ready(outReady), .out_sum(outSumA),
    .out_overflow(outOvfA), .out_underflow(outUnfA), .out_nan(outNanA), .out_count(outCountA)
  );

  fp_accum_ctrl #(.CNT_W(2)) dutB (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReadyB), .in_data(inData),
    .in_sub(inSub), .in_last(inLast), .op_a(opAB), .op_b(opBB), .op_sub(opSubB),
    .op_result(opResB), .op_overflow(opOvfB), .op_underflow(opUnfB),
    .out_valid(outValidB), .out_ready(outReady), .out_sum(outSumB),
    .out_overflow(outOvfB), .out_underflow(outUnfB), .out_nan(outNanB), .out_count(outCountB)
  );

  // Zero exponent is treated as signed zero; normals are widened exactly to double.
  function automatic real fpToReal(input logic [31:0] v);
    logic [63:0] d;
    if (v[30:23] == 8'd0) d = {v[31], 63'd0};
    else d = {v[31], 11'(v[30:23]) + 11'd896, v[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Narrowing truncates; stimulus values are chosen so every sum is exact.
  function automatic addOut_t realToFp(input real r);
    logic [63:0] d;
    int e;
    addOut_t o;
    o = '0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    if (d[62:0] == 63'd0) o.res = {d[63], 31'd0};
    else if (e >= 255) begin
      o.res = {d[63], 8'hFF, 23'd0};
      o.ovf = 1'b1;
    end else if (e <= 0) begin
      o.res = {d[63], 31'd0};
      o.unf = 1'b1;
    end else o.res = {d[63], e[7:0], d[51:29]};
    return o;
  endfunction

  function automatic addOut_t fpAddSub(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic [31:0] bEff;
    logic aInf, bInf;
    addOut_t o;
    o = '0;
    bEff = {b[31] ^ sub, b[30:0]};
    aInf = (a[30:23] == 8'hFF);
    bInf = (bEff[30:23] == 8'hFF);
    if (is_nan(a) || is_nan(bEff)) o.res = 32'h7FC00000;
    else if (aInf && bInf) o.res = (a[31] == bEff[31]) ? a : 32'h7FC00000;
    else if (aInf) o.res = a;
    else if (bInf) o.res = bEff;
    else o = realToFp(fpToReal(a) + fpToReal(bEff));
    return o;
  endfunction

  assign {opResA, opOvfA, opUnfA} = fpAddSub(opAA, opBA, opSubA);
  assign {opResB, opOvfB, opUnfB} = fpAddSub(opAB, opBB, opSubB);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives one operand and returns one tick after the edge that accepted it.
  task automatic sendOperand(input logic [31:0] data, input logic sub, input logic last);
    int guard;
    guard = 0;
    inValid = 1'b1;
    inData  = data;
    inSub   = sub;
    inLast  = last;
    while (!inReadyA && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!inReadyA) checkOutput("accept_timeout", inReadyA, 1);
    @(posedge clk); #1;
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  // Sends the queued packet, checks the result against the reference fold,
  // holds out_ready low for holdCycles checking stability, then hands off.
  task automatic applyStimulus(input string tag, input int maxGap, input int holdCycles);
    logic [31:0] expSum;
    logic expOvf, expUnf, expNan;
    int n, guard;
    addOut_t t;
    expSum = FP32_POS_ZERO;
    expOvf = 1'b0;
    expUnf = 1'b0;
    n = pktData.size();
    for (int i = 0; i < n; i++) begin
      t = fpAddSub(expSum, pktData[i], pktSub[i]);
      expSum = t.res;
      expOvf |= t.ovf;
      expUnf |= t.unf;
      repeat ($urandom_range(maxGap, 0)) begin
        @(posedge clk); #1;
      end
      sendOperand(pktData[i], pktSub[i], i == n - 1);
    end
    expNan = (expSum[30:23] == 8'hFF) && (expSum[22:0] != 23'd0);
    guard = 0;
    while (!outValidA && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput({tag, "_valid"}, outValidA, 1);
    checkOutput({tag, "_validB"}, outValidB, 1);
    checkOutput({tag, "_sum"}, outSumA, expSum);
    checkOutput({tag, "_sumB"}, outSumB, expSum);
    checkOutput({tag, "_ovf"}, outOvfA, expOvf);
    checkOutput({tag, "_unf"}, outUnfA, expUnf);
    checkOutput({tag, "_nan"}, outNanA, expNan);
    checkOutput({tag, "_cnt16"}, outCountA, n);
    checkOutput({tag, "_cnt2"}, outCountB, (n > 3) ? 3 : n);
    for (int c = 0; c < holdCycles; c++) begin
      inValid = 1'b1;
      inData  = $urandom;
      inSub   = 1'($urandom);
      @(posedge clk); #1;
      checkOutput({tag, "_hold_valid"}, outValidA, 1);
      checkOutput({tag, "_hold_sum"}, outSumA, expSum);
      checkOutput({tag, "_hold_inready"}, inReadyA, 0);
      checkOutput({tag, "_hold_cnt"}, outCountA, n);
    end
    inValid   = 1'b0;
    gotSum    = outSumA;
    gotOvf    = outOvfA;
    gotUnf    = outUnfA;
    gotNan    = outNanA;
    gotCountA = outCountA;
    gotCountB = outCountB;
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    checkOutput({tag, "_after_valid"}, outValidA, 0);
    checkOutput({tag, "_after_inready"}, inReadyA, 1);
    pktData.delete();
    pktSub.delete();
  endtask

  task automatic pushOp(input logic [31:0] data, input logic sub);
    pktData.push_back(data);
    pktSub.push_back(sub);
  endtask

  initial begin
    rst = 1'b1;
    inValid = 1'b0;
    inData = '0;
    inSub = 1'b0;
    inLast = 1'b0;
    outReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_inready", inReadyA, 1);
    checkOutput("rst_outvalid", outValidA, 0);
    checkOutput("rst_sum", outSumA, 32'h0);
    checkOutput("rst_count", outCountA, 0);
    checkOutput("rst_opb", opBA, 32'h0);
    checkOutput("rst_opsub", opSubA, 0);

    pushOp(32'h3E000000, 1'b0);
    pushOp(32'h41160000, 1'b0);
    applyStimulus("add2", 0, 0);
    checkOutput("add2_lit", gotSum, 32'h41180000);

    pushOp(32'h3E000000, 1'b0);
    pushOp(32'h41160000, 1'b1);
    applyStimulus("sub2", 1, 0);
    checkOutput("sub2_lit", gotSum, 32'hC1140000);

    // Single-operand packet: S_ADD for one cycle, then result valid.
    sendOperand(32'h3E000000, 1'b1, 1'b1);
    checkOutput("lat_add_valid", outValidA, 0);
    checkOutput("lat_add_inready", inReadyA, 0);
    @(posedge clk); #1;
    checkOutput("lat_out_valid", outValidA, 1);
    checkOutput("lat_out_sum", outSumA, 32'hBE000000);
    checkOutput("lat_out_cnt", outCountA, 1);
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;

    pushOp(FP32_POS_INF, 1'b0);
    pushOp(FP32_NEG_INF, 1'b1);
    applyStimulus("inf_ok", 0, 0);
    checkOutput("inf_ok_lit", gotSum, 32'h7F800000);
    checkOutput("inf_ok_nan", gotNan, 0);

    pushOp(FP32_POS_INF, 1'b0);
    pushOp(FP32_POS_INF, 1'b1);
    applyStimulus("inf_nan", 0, 0);
    checkOutput("inf_nan_flag", gotNan, 1);

    pushOp(32'h7F7FFFFF, 1'b0);
    pushOp(32'h7F7FFFFF, 1'b0);
    pushOp(32'h3F800000, 1'b0);
    applyStimulus("ovf", 0, 0);
    checkOutput("ovf_sticky", gotOvf, 1);
    checkOutput("ovf_sum", gotSum, 32'h7F800000);

    pushOp(32'h00800001, 1'b0);
    pushOp(32'h00800000, 1'b1);
    pushOp(32'h3F800000, 1'b0);
    applyStimulus("unf", 0, 0);
    checkOutput("unf_sticky", gotUnf, 1);
    checkOutput("unf_sum", gotSum, 32'h3F800000);

    pushOp(32'h40000000, 1'b0);
    applyStimulus("bp", 0, 5);
    checkOutput("bp_lit", gotSum, 32'h40000000);
    pushOp(32'h3F800000, 1'b1);
    applyStimulus("bp_next", 0, 0);
    checkOutput("bp_next_lit", gotSum, 32'hBF800000);

    sendOperand(32'h3F800000, 1'b0, 1'b0);
    sendOperand(32'h40000000, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rstmid_inready", inReadyA, 1);
    checkOutput("rstmid_outvalid", outValidA, 0);
    checkOutput("rstmid_sum", outSumA, 32'h0);
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("rstmid_no_pulse", outValidA, 0);
    end
    pushOp(32'h41160000, 1'b0);
    applyStimulus("rstmid_next", 0, 0);
    checkOutput("rstmid_next_lit", gotSum, 32'h41160000);
    checkOutput("rstmid_next_cnt", gotCountA, 1);

    sendOperand(32'h3F800000, 1'b0, 1'b1);
    @(posedge clk); #1;
    checkOutput("rstout_valid_before", outValidA, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rstout_dropped", outValidA, 0);
    checkOutput("rstout_inready", inReadyA, 1);

    repeat (5) pushOp(32'h3F800000, 1'b0);
    applyStimulus("sat", 0, 0);
    checkOutput("sat_sum", gotSum, 32'h40A00000);
    checkOutput("sat_cnt2", gotCountB, 3);
    checkOutput("sat_cnt16", gotCountA, 5);

    for (int p = 0; p < 25; p++) begin
      int len;
      len = $urandom_range(6, 1);
      for (int i = 0; i < len; i++) begin
        int k;
        addOut_t v;
        k = int'($urandom_range(4000, 0)) - 2000;
        v = realToFp(real'(k) / 8.0);
        pushOp(v.res, 1'($urandom));
      end
      applyStimulus($sformatf("rnd%0d", p), 2, $urandom_range(2, 0));
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fp_accum_ctrl.md
Name: fp_accum_ctrl

Overview:
- Streaming initiator for the combinational single-precision add_sub unit.
- Accepts a packet of IEEE-754 fp32 operands over a valid/ready stream and issues one add or subtract per operand against a running accumulator.
- Presents the final sum, sticky overflow/underflow/NaN flags and an element count on a valid/ready output.
- Sits in the parent between an operand source and an add_sub instance; the adder is wired to this block's op_* ports at the parent level.

Parameters:
- CNT_W, 16, width of the element counter; the counter saturates at all-ones.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept an operand this cycle
- in_data  in  32  fp32 operand
- in_sub  in  1  1: acc - in_data; 0: acc + in_data
- in_last  in  1  final operand of the packet
- op_a  out  32  to add_sub A (accumulator)
- op_b  out  32  to add_sub B (latched operand)
- op_sub  out  1  to add_sub add_or_sub
- op_result  in  32  from add_sub result (same-cycle combinational)
- op_overflow  in  1  from add_sub overflow
- op_underflow  in  1  from add_sub underflow
- out_valid  out  1  packet result valid
- out_ready  in  1  consumer accepts the result
- out_sum  out  32  final accumulator value
- out_overflow  out  1  sticky OR of op_overflow over the packet
- out_underflow  out  1  sticky OR of op_underflow over the packet
- out_nan  out  1  out_sum exponent is 0xFF and mantissa is non-zero
- out_count  out  CNT_W  number of operands consumed, saturating

Behaviour:
- States are S_ACC, S_ADD and S_OUT. Reset state is S_ACC.
- Reset values: acc=0x00000000, all flags 0, count 0, opb/sub/last registers 0, in_ready=1, out_valid=0.
- S_ACC:
  - in_ready=1.
  - On in_valid: latch in_data to opb_reg, in_sub to sub_reg, in_last to last_reg, then go to S_ADD.
- S_ADD:
  - in_ready=0.
  - op_a=acc_reg, op_b=opb_reg, op_sub=sub_reg.
  - At the edge: acc_reg<=op_result; ovf|=op_overflow; unf|=op_underflow; count<=count+1, holding at all-ones.
  - If last_reg, go to S_OUT; otherwise go to S_ACC.
- S_OUT:
  - out_valid=1; out_sum/flags/count come directly from registers and are stable while out_valid && !out_ready.
  - On out_ready: clear acc to +0, clear flags and count, go to S_ACC.
- op_a/op_b/op_sub are driven from registers in every state. The only cycle the parent may sample op_result is S_ADD.
- Timing:
  - Throughput is one operand per 2 cycles.
  - For a single-operand packet, latency from the in_valid&&in_ready edge to out_valid is 2 cycles.
  - in_ready is 0 throughout S_ADD and S_OUT, so the next packet is back-pressured until the result is taken.
- Arithmetic: the accumulator starts at +0 and every operation is IEEE through add_sub, so a first operand with in_sub=1 yields -x. No rounding or special-case handling exists outside add_sub.
- out_nan is computed from acc_reg (exp==8'hFF && man!=0) and registered as part of the output.
- Boundary conditions:
  - A packet with in_last on its first element is valid.
  - in_valid is ignored outside S_ACC.
  - Once the count saturates it holds until S_OUT is acknowledged.
  - rst asserted mid-packet discards the in-flight operand and accumulator. The block returns to S_ACC next cycle with no out_valid pulse.
  - rst while out_valid=1 drops the result.

Decomposition:
- Shared package fp32_pkg holds:
  - constants FP32_POS_ZERO=0x00000000, FP32_POS_INF=0x7F800000, FP32_NEG_INF=0xFF800000;
  - field widths EXP_W=8, MAN_W=23;
  - the state encoding localparams;
  - an is_nan function.
- No sub-module. add_sub is instantiated by the parent and by the bench, not inside this block.

Test Plan:
- Two-operand add: 0x3E000000 (0.125, sub=0) then 0x41160000 (9.375, sub=0, last) -> out_sum=0x41180000 (9.5), count=2, flags 0.
- Subtract: 0x3E000000 (sub=0) then 0x41160000 (sub=1, last) -> out_sum=0xC1140000 (-9.25); a single 0x3E000000 with sub=1 and last -> 0xBE000000.
- Infinities: 0x7F800000 (sub=0) then 0xFF800000 (sub=1) -> 0x7F800000, out_nan=0. 0x7F800000 then 0x7F800000 (sub=1) -> out_nan=1.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid, out_sum and in_ready=0 held stable. The next packet is accepted the cycle after the out_ready handshake, with acc restarting at +0.
- Reset mid-packet: assert rst in S_ADD of the 2nd operand -> next cycle in_ready=1, out_valid=0. A following one-operand packet 0x41160000 yields exactly 0x41160000, count=1.
- Counter saturation with CNT_W=2: 5 operands of 0x3F800000 (1.0) -> out_count=3, out_sum=0x40A00000 (5.0).
